// File: rtl/z2_bus_master.sv
// Zorro II DMA bus master: arbitrates with BR/BG/BGACK and runs single-word
// 68000-style AS/UDS/LDS/DTACK cycles on behalf of card-side command sources.
module z2_bus_master #(
    parameter int T_ASU     = 3,
    parameter int T_DSU     = 2,
    parameter int T_RD      = 2,
    parameter int T_HOLD    = 2,
    parameter int TIMEOUT   = 255,
    parameter int HOLD_IDLE = 8
) (
    input  logic        z_sample_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [22:0] cmd_addr,
    input  logic [1:0]  cmd_be,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        znBR,
    input  logic        znBG,
    input  logic        znBGACK_in,
    input  logic        znAS_in,
    output logic        znBGACK,
    output logic        bus_oe,
    output logic [22:0] zA,
    output logic        znAS,
    output logic        znUDS,
    output logic        znLDS,
    output logic        zREAD_out,
    output logic [15:0] zD_out,
    output logic        zD_oe,
    input  logic [15:0] zD_in,
    input  logic        znDTACK,
    input  logic        znBERR
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_OWN, S_ADDR, S_STROBE, S_WAIT_ACK, S_READ_CAP, S_END, S_RELEASE
    } state_t;

    localparam logic [8:0] ASU_LAST  = 9'(T_ASU - 1);
    localparam logic [8:0] DSU_LAST  = 9'(T_DSU - 1);
    localparam logic [8:0] RD_LAST   = 9'(T_RD - 1);
    localparam logic [8:0] HOLD_LAST = 9'(T_HOLD - 1);
    localparam logic [8:0] TMO_LAST  = 9'(TIMEOUT);
    localparam logic [8:0] IDLE_LAST = 9'(HOLD_IDLE - 1);

    state_t      state_q;
    logic [8:0]  cnt_q;
    logic [4:0]  sync1_q, sync2_q;
    logic        pend_q, abort_q;
    logic        write_q;
    logic [22:0] addr_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;
    logic        cmd_ready_q, rsp_valid_q, rsp_err_q;
    logic [15:0] rsp_rdata_q;
    logic        znBR_q, znBGACK_q, bus_oe_q, znAS_q, znUDS_q, znLDS_q, zREAD_q, zD_oe_q;
    logic [22:0] zA_q;
    logic [15:0] zD_out_q;

    logic bg_n_s, bgack_n_s, as_n_s, dtack_n_s, berr_n_s, accept_s;

    // Two-flop synchronizers for the asynchronous bus inputs (idle level is high)
    always_ff @(posedge z_sample_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 5'b11111;
            sync2_q <= 5'b11111;
        end else begin
            sync1_q <= {znBG, znBGACK_in, znAS_in, znDTACK, znBERR};
            sync2_q <= sync1_q;
        end
    end

    assign {bg_n_s, bgack_n_s, as_n_s, dtack_n_s, berr_n_s} = sync2_q;
    assign accept_s = cmd_valid & cmd_ready_q;

    // Bus-cycle sequencer; every bus and response output is a register of this FSM
    always_ff @(posedge z_sample_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 9'd0;
            pend_q      <= 1'b0;
            abort_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 23'd0;
            be_q        <= 2'b00;
            wdata_q     <= 16'd0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'd0;
            znBR_q      <= 1'b1;
            znBGACK_q   <= 1'b1;
            bus_oe_q    <= 1'b0;
            znAS_q      <= 1'b1;
            znUDS_q     <= 1'b1;
            znLDS_q     <= 1'b1;
            zREAD_q     <= 1'b1;
            zD_oe_q     <= 1'b0;
            zA_q        <= 23'd0;
            zD_out_q    <= 16'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_be == 2'b00) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            write_q <= cmd_write;
                            addr_q  <= cmd_addr;
                            be_q    <= cmd_be;
                            wdata_q <= cmd_wdata;
                            pend_q  <= 1'b1;
                            znBR_q  <= 1'b0;
                            state_q <= S_REQ;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Take the bus only once it is fully idle and nobody else holds BGACK
                    if (!bg_n_s && as_n_s && bgack_n_s && dtack_n_s) begin
                        znBGACK_q <= 1'b0;
                        znBR_q    <= 1'b1;
                        bus_oe_q  <= 1'b1;
                        cnt_q     <= 9'd0;
                        state_q   <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (pend_q) begin
                        pend_q      <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        zA_q        <= addr_q;
                        zREAD_q     <= ~write_q;
                        if (write_q) begin
                            zD_out_q <= wdata_q;
                            zD_oe_q  <= 1'b1;
                        end
                        cnt_q   <= 9'd0;
                        state_q <= S_ADDR;
                    end else if (accept_s) begin
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= 9'd0;
                        if (cmd_be == 2'b00) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            write_q <= cmd_write;
                            addr_q  <= cmd_addr;
                            be_q    <= cmd_be;
                            wdata_q <= cmd_wdata;
                            pend_q  <= 1'b1;
                        end
                    end else if (cnt_q == IDLE_LAST) begin
                        cmd_ready_q <= 1'b0;
                        bus_oe_q    <= 1'b0;
                        state_q     <= S_RELEASE;
                    end else begin
                        cnt_q       <= cnt_q + 9'd1;
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (cnt_q == ASU_LAST) begin
                        znAS_q  <= 1'b0;
                        cnt_q   <= 9'd0;
                        state_q <= S_STROBE;
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt_q == DSU_LAST) begin
                        znUDS_q <= ~be_q[1];
                        znLDS_q <= ~be_q[0];
                        cnt_q   <= 9'd0;
                        state_q <= S_WAIT_ACK;
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                S_WAIT_ACK: begin
                    // BERR takes priority over a simultaneous DTACK
                    if (!berr_n_s || (dtack_n_s && cnt_q == TMO_LAST)) begin
                        {znAS_q, znUDS_q, znLDS_q} <= 3'b111;
                        zD_oe_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        abort_q     <= 1'b1;
                        cnt_q       <= 9'd0;
                        state_q     <= S_END;
                    end else if (!dtack_n_s) begin
                        cnt_q <= 9'd0;
                        if (write_q) begin
                            {znAS_q, znUDS_q, znLDS_q} <= 3'b111;
                            zD_oe_q     <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            abort_q     <= 1'b0;
                            state_q     <= S_END;
                        end else begin
                            state_q <= S_READ_CAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                S_READ_CAP: begin
                    if (cnt_q == RD_LAST) begin
                        rsp_rdata_q <= zD_in;
                        {znAS_q, znUDS_q, znLDS_q} <= 3'b111;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        abort_q     <= 1'b0;
                        cnt_q       <= 9'd0;
                        state_q     <= S_END;
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                S_END: begin
                    if (cnt_q < HOLD_LAST) begin
                        cnt_q <= cnt_q + 9'd1;
                    end else if (dtack_n_s && berr_n_s) begin
                        cnt_q <= 9'd0;
                        if (abort_q) begin
                            bus_oe_q <= 1'b0;
                            state_q  <= S_RELEASE;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_OWN;
                        end
                    end
                end
                S_RELEASE: begin
                    znBGACK_q   <= 1'b1;
                    zREAD_q     <= 1'b1;
                    abort_q     <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign znBR      = znBR_q;
    assign znBGACK   = znBGACK_q;
    assign bus_oe    = bus_oe_q;
    assign zA        = zA_q;
    assign znAS      = znAS_q;
    assign znUDS     = znUDS_q;
    assign znLDS     = znLDS_q;
    assign zREAD_out = zREAD_q;
    assign zD_out    = zD_out_q;
    assign zD_oe     = zD_oe_q;

endmodule
